// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core MW-stage
// load/store path and a debug/DMA requester; tracks fixed read latency.
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  core_req,
    input  logic                  core_wr,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [DATA_W/8-1:0]   core_mask,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,

    input  logic                  dbg_req,
    input  logic                  dbg_wr,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [DATA_W/8-1:0]   dbg_mask,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,

    output logic                  mem_cs,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_mask,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  fsm_state
);

    localparam logic [2:0] LAT      = 3'(MEM_LAT);
    localparam logic       OWN_CORE = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic       last_owner, last_owner_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       pick_core, pick_dbg;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_CORE;
            last_owner <= OWN_DBG;
            cnt        <= 3'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        pick_core      = 1'b0;
        pick_dbg       = 1'b0;
        core_gnt       = 1'b0;
        dbg_gnt        = 1'b0;
        core_rvalid    = 1'b0;
        dbg_rvalid     = 1'b0;
        mem_cs         = 1'b1;
        mem_wr         = 1'b1;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_mask       = '0;

        unique case (state)
            IDLE: begin
                // Grants are gated by rst_n so a held request cannot leak a
                // grant while reset is asserted.
                if (rst_n) begin
                    pick_core = core_req && (!dbg_req || last_owner == OWN_DBG);
                    pick_dbg  = dbg_req && !pick_core;
                end
                if (pick_core) begin
                    core_gnt       = 1'b1;
                    mem_cs         = 1'b0;
                    mem_wr         = core_wr;
                    mem_addr       = core_addr;
                    mem_wdata      = core_wdata;
                    mem_mask       = core_mask;
                    last_owner_nxt = OWN_CORE;
                    if (core_wr) begin
                        owner_nxt = OWN_CORE;
                        cnt_nxt   = 3'd1;
                        state_nxt = WAIT;
                    end
                end else if (pick_dbg) begin
                    dbg_gnt        = 1'b1;
                    mem_cs         = 1'b0;
                    mem_wr         = dbg_wr;
                    mem_addr       = dbg_addr;
                    mem_wdata      = dbg_wdata;
                    mem_mask       = dbg_mask;
                    last_owner_nxt = OWN_DBG;
                    if (dbg_wr) begin
                        owner_nxt = OWN_DBG;
                        cnt_nxt   = 3'd1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == LAT) begin
                    core_rvalid = (owner == OWN_CORE);
                    dbg_rvalid  = (owner == OWN_DBG);
                    cnt_nxt     = 3'd0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign core_rdata = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid  ? mem_rdata : '0;

    // The core is released only by its own store grant or its own load data.
    assign core_stall = rst_n && core_req
                        && !(core_gnt && !core_wr)
                        && !core_rvalid;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: transaction-level reference model,
// memory slave, expected-command and expected-read scoreboards.
module tb_dmem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = DATA_W / 8;
    localparam int MEM_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic              core_req, core_wr;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [MASK_W-1:0] core_mask;
    logic              core_gnt, core_rvalid, core_stall;
    logic [DATA_W-1:0] core_rdata;
    logic              dbg_req, dbg_wr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [MASK_W-1:0] dbg_mask;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_cs, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_mask;
    logic [DATA_W-1:0] mem_rdata;
    logic              fsm_state;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_mask(core_mask), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_mask(dbg_mask), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input int act, input int exp);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    endtask

    // ---------------- memory contents (word granular) ----------------
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < MASK_W; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] slv_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] rd_sched [int];

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] k;
        k = a & ~ADDR_W'(3);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    // ---------------- memory slave ----------------
    always @(negedge clk) begin
        logic [ADDR_W-1:0] k;
        if (rst_n && !mem_cs) begin
            k = mem_addr & ~ADDR_W'(3);
            if (!slv_mem.exists(k)) slv_mem[k] = init_word(k);
            if (!mem_wr) slv_mem[k] = merge(slv_mem[k], mem_wdata, mem_mask);
            else         rd_sched[cyc + MEM_LAT] = slv_mem[k];
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_sched.exists(cyc)) begin
            mem_rdata = rd_sched[cyc];
            rd_sched.delete(cyc);
        end else begin
            mem_rdata = $urandom;
        end
    end

    // ---------------- reference model + scoreboards ----------------
    typedef struct packed {
        logic              side;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } cmd_t;

    typedef struct packed {
        logic        side;
        logic [31:0] due;
        logic [DATA_W-1:0] data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  exp_q[$];

    int   busy_until = -1;   // cycle of the pending load's data return
    logic m_last     = 1'b1; // 1 = dbg was served last
    logic p_side     = 1'b0;
    logic m_free, win_core, win_dbg, e_stall;
    cmd_t c;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_until = -1;
            m_last     = 1'b1;
            exp_q.delete();
            check("reset_ctrl", {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_stall, mem_cs, mem_wr, fsm_state},
                  8'b0000_0110);
            check("reset_bus", {mem_addr, mem_wdata, mem_mask, core_rdata, dbg_rdata}, '0);
        end else begin
            m_free   = (cyc > busy_until);
            check("fsm_state", fsm_state, !m_free);
            win_core = m_free && core_req && (!dbg_req || m_last);
            win_dbg  = m_free && dbg_req && !win_core;
            if (win_core || win_dbg) begin
                c.side  = win_dbg;
                c.wr    = win_dbg ? dbg_wr    : core_wr;
                c.addr  = win_dbg ? dbg_addr  : core_addr;
                c.wdata = win_dbg ? dbg_wdata : core_wdata;
                c.mask  = win_dbg ? dbg_mask  : core_mask;
                cmd_q.push_back(c);
                m_last = win_dbg;
                if (c.wr) begin
                    busy_until = cyc + MEM_LAT;
                    p_side     = win_dbg;
                    exp_q.push_back('{side: win_dbg, due: 32'(busy_until), data: ref_read(c.addr)});
                end else begin
                    ref_mem[c.addr & ~ADDR_W'(3)] = merge(ref_read(c.addr), c.wdata, c.mask);
                end
            end
            e_stall = core_req && !(win_core && !core_wr) && !(busy_until == cyc && !p_side);
            check("grants", {core_gnt, dbg_gnt}, {win_core, win_dbg});
            check("core_stall", core_stall, e_stall);
        end
    end

    // Monitor: consumes expected commands and read returns as the DUT shows them.
    always @(negedge clk) begin
        cmd_t e;
        rd_t  r;
        #1;
        if (rst_n) begin
            if (!mem_cs) begin
                if (cmd_q.size() == 0) fail_event("unexpected_cmd", 1, 0);
                else begin
                    e = cmd_q.pop_front();
                    check("mem_cmd", {mem_wr, mem_addr, mem_wdata, mem_mask},
                          {e.wr, e.addr, e.wdata, e.mask});
                end
            end else begin
                check("mem_idle", {mem_wr, mem_addr, mem_wdata, mem_mask}, {1'b1, 68'b0});
            end
            if (core_rvalid || dbg_rvalid) begin
                if (exp_q.size() == 0) fail_event("unexpected_rvalid", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    check("rvalid_side", {core_rvalid, dbg_rvalid}, {~r.side, r.side});
                    check("rvalid_time", 32'(cyc), r.due);
                    check("rdata_owner", r.side ? dbg_rdata : core_rdata, r.data);
                    check("rdata_other", r.side ? core_rdata : dbg_rdata, '0);
                end
            end else begin
                check("rdata_idle", {core_rdata, dbg_rdata}, '0);
                if (exp_q.size() != 0 && int'(exp_q[0].due) <= cyc) begin
                    fail_event("missed_rvalid", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic core_txn(input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] m);
        int n;
        @(posedge clk); #1;
        core_req = 1'b1; core_wr = wr; core_addr = a; core_wdata = wd; core_mask = m;
        n = 0;
        do begin @(negedge clk); n++; end while (!core_gnt && n < 40);
        if (!core_gnt) begin fail_event("core_gnt_timeout", 0, 1); return; end
        if (wr) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!core_rvalid && n < 10);
            if (!core_rvalid) fail_event("core_rvalid_timeout", 0, 1);
        end
    endtask

    task automatic core_idle();
        @(posedge clk); #1;
        core_req = 1'b0;
    endtask

    task automatic dbg_txn(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] m);
        int n;
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_wdata = wd; dbg_mask = m;
        n = 0;
        do begin @(negedge clk); n++; end while (!dbg_gnt && n < 40);
        if (!dbg_gnt) begin fail_event("dbg_gnt_timeout", 0, 1); return; end
        if (wr) begin
            @(posedge clk); #1;
            dbg_req = 1'b0;
            n = 0;
            while (!dbg_rvalid && n < 10) begin @(negedge clk); n++; end
            if (!dbg_rvalid) fail_event("dbg_rvalid_timeout", 0, 1);
        end
    endtask

    task automatic dbg_idle();
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; mem_rdata = '0;
        core_req = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_mask = '0;
        dbg_req  = 0; dbg_wr  = 0; dbg_addr  = '0; dbg_wdata  = '0; dbg_mask  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // lone core store, then a load returning data written by dbg
        core_txn(1'b0, 32'h100, 32'hDEADBEEF, 4'b1111); core_idle();
        dbg_txn(1'b0, 32'h200, 32'h12345678, 4'b1111);  dbg_idle();
        core_txn(1'b1, 32'h200, 32'h0, 4'b1111);         core_idle();

        // dbg arrives one cycle into a core load and must wait for it
        fork
            begin core_txn(1'b1, 32'h100, 32'h0, 4'b1111); core_idle(); end
            begin @(posedge clk); dbg_txn(1'b0, 32'h300, 32'hCAFEF00D, 4'b0101); dbg_idle(); end
        join

        // reset pulse one cycle into a core load
        @(posedge clk); #1;
        core_req = 1'b1; core_wr = 1'b1; core_addr = 32'h104; core_mask = 4'b1111;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; core_req = 1'b0;
        repeat (4) @(posedge clk);

        // continuous contention of stores: core first, then alternating
        fork
            begin
                for (int i = 0; i < 4; i++) core_txn(1'b0, 32'h110 + 32'(4*i), $urandom, 4'b1111);
                core_idle();
            end
            begin
                for (int i = 0; i < 4; i++) dbg_txn(1'b0, 32'h120 + 32'(4*i), $urandom, 4'b1111);
                dbg_idle();
            end
        join

        // dbg load of a known pattern
        dbg_txn(1'b0, 32'h400, 32'hA5A5A5A5, 4'b1111); dbg_idle();
        dbg_txn(1'b1, 32'h400, 32'h0, 4'b1111);         dbg_idle();

        // randomized traffic from both sides
        fork
            for (int i = 0; i < 60; i++) begin
                int g;
                g = $urandom_range(0, 2);
                if (g != 0) begin core_idle(); repeat (g - 1) @(posedge clk); end
                core_txn(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 31)),
                         $urandom, 4'($urandom_range(0, 15)));
            end
            for (int i = 0; i < 60; i++) begin
                int g;
                g = $urandom_range(0, 2);
                if (g != 0) begin dbg_idle(); repeat (g - 1) @(posedge clk); end
                dbg_txn(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 31)),
                        $urandom, 4'($urandom_range(0, 15)));
            end
        join
        core_idle();
        dbg_idle();
        repeat (8) @(posedge clk);

        check("cmd_q_drained", 128'(cmd_q.size()), 128'd0);
        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
